// File: rtl/toggle_event_decoder_if.sv
// Bus for toggle_event_decoder: the toggle line and acknowledge in, event status out.
// The decoder is the slave; the consumer and status logic is the master.
interface toggle_event_decoder_if #(
    parameter int CNT_W = 8
);
    logic             tog_in;
    logic             ack_in;
    logic             evt_pulse;
    logic             evt_pending;
    logic [CNT_W-1:0] evt_count;
    logic             overrun;
    logic             level_out;

    modport master (
        output tog_in,
        output ack_in,
        input  evt_pulse,
        input  evt_pending,
        input  evt_count,
        input  overrun,
        input  level_out
    );

    modport slave (
        input  tog_in,
        input  ack_in,
        output evt_pulse,
        output evt_pending,
        output evt_count,
        output overrun,
        output level_out
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// Receive end of a toggle-signalling link: synchronizes the toggle line and turns each level change into an event.
// Define TOGGLE_FILTER_EN to require a mismatch to persist FILT_LEN cycles before it is accepted.
module toggle_event_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    toggle_event_decoder_if.slave bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         INIT_W  = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (FILT_LEN < 1) begin : g_bad_filt
            $error("FILT_LEN must be at least 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [0:0]             state_q, state_d;
    logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sync_out;
    logic                   mismatch;
    logic                   accept;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign mismatch = (state_q == ST_RUN) && (sync_out != level_q);

`ifdef TOGGLE_FILTER_EN
    localparam int HOLD_W = $clog2(FILT_LEN + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Accept only once the mismatch has been seen FILT_LEN cycles in a row.
    always_comb begin
        hold_d = '0;
        accept = 1'b0;
        if (mismatch) begin
            if (hold_q == HOLD_W'(FILT_LEN - 1)) begin
                accept = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign accept = mismatch;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.tog_in};
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        level_d    = level_q;
        pulse_d    = 1'b0;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        count_d    = count_q;

        if (state_q == ST_INIT) begin
            if (init_cnt_q == INIT_W'(SYNC_STAGES - 1)) begin
                state_d = ST_RUN;
                // Take the level sync_out settles to on this edge, so a line held high through reset is not an event.
                level_d = sync_q[SYNC_STAGES-2];
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end else if (accept) begin
            level_d   = ~level_q;
            pulse_d   = 1'b1;
            count_d   = count_q + 1'b1;
            pending_d = 1'b1;
            if (pending_q && !bus.ack_in) begin
                overrun_d = 1'b1;
            end
        end else if (bus.ack_in && pending_q) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign bus.evt_pulse   = pulse_q;
    assign bus.evt_pending = pending_q;
    assign bus.evt_count   = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.level_out   = level_q;
endmodule

// File: tb/tb_toggle_event_decoder.sv
// Self-checking bench for toggle_event_decoder: directed scenarios plus random traffic against an edge-history model.
// Build with TOGGLE_FILTER_EN defined to exercise the filtered variant.
module tb_toggle_event_decoder;
    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
`ifdef TOGGLE_FILTER_EN
    localparam int FILT       = 3;
    localparam int GLITCH_EVS = 0;
`else
    localparam int FILT       = 1;
    localparam int GLITCH_EVS = 2;
`endif
    localparam int ACC_LAT  = SYNC + FILT - 1;
    localparam int HIST_MAX = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;

    toggle_event_decoder_if #(.CNT_W(CNT_W)) bus ();

    toggle_event_decoder #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: the line value seen by the detector at edge n is the tog_in sampled SYNC edges earlier.
    bit samp [HIST_MAX];
    int edge_n   = 0;
    int last_rst = 0;
    int m_hold   = 0;
    int m_count  = 0;
    bit m_level, m_pending, m_over, m_pulse;
    bit cur_tog  = 1'b0;

    task automatic model_edge(input bit t, input bit a, input bit r);
        int since;
        bit line;
        edge_n++;
        m_pulse = 1'b0;
        if (r) begin
            last_rst  = edge_n;
            m_level   = 1'b0;
            m_pending = 1'b0;
            m_over    = 1'b0;
            m_count   = 0;
            m_hold    = 0;
            return;
        end
        samp[edge_n] = t;
        since = edge_n - last_rst;
        if (since == SYNC) begin
            m_level = samp[last_rst + 1];
        end else if (since > SYNC) begin
            line = samp[edge_n - SYNC];
            if (line != m_level) m_hold++;
            else m_hold = 0;
            if (m_hold >= FILT) begin
                m_hold  = 0;
                m_level = line;
                m_pulse = 1'b1;
                m_count = (m_count + 1) % (1 << CNT_W);
                if (m_pending && !a) m_over = 1'b1;
                m_pending = 1'b1;
            end else if (a && m_pending) begin
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        cmp("evt_pulse",   int'(bus.evt_pulse),   int'(m_pulse));
        cmp("evt_pending", int'(bus.evt_pending), int'(m_pending));
        cmp("evt_count",   int'(bus.evt_count),   m_count);
        cmp("overrun",     int'(bus.overrun),     int'(m_over));
        cmp("level_out",   int'(bus.level_out),   int'(m_level));
    endtask

    // Inputs change on the falling edge; outputs are checked on the following falling edge.
    task automatic applyStimulus(input bit t, input bit a, input bit r);
        bus.tog_in = t;
        bus.ack_in = a;
        rst        = r;
        cur_tog    = t;
        model_edge(t, a, r);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(cur_tog, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit t);
        for (int i = 0; i < 3; i++) applyStimulus(t, 1'b0, 1'b1);
    endtask

    initial begin
        int pulse_at;
        int pulses;
        int base;
        bus.tog_in = 1'b1;
        bus.ack_in = 1'b0;
        @(negedge clk);

        // Reset with the line already high: no event after INIT, level follows the line.
        do_reset(1'b1);
        cmp("reset_pulse", int'(bus.evt_pulse), 0);
        cmp("reset_count", int'(bus.evt_count), 0);
        cmp("reset_level", int'(bus.level_out), 0);
        idle(SYNC);
        cmp("init_level_high", int'(bus.level_out), 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (bus.evt_pulse) pulses++;
        end
        cmp("init_no_pulse", pulses, 0);
        cmp("init_count", int'(bus.evt_count), 0);

        // Single toggle: pulse exactly ACC_LAT edges after the first sampling edge.
        pulse_at = -1;
        for (int i = 0; i < ACC_LAT + 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (bus.evt_pulse && pulse_at < 0) pulse_at = i;
        end
        cmp("single_latency", pulse_at, ACC_LAT);
        cmp("single_count", int'(bus.evt_count), 1);
        cmp("single_pending", int'(bus.evt_pending), 1);

        // Handshake, then an accept coinciding with ack.
        applyStimulus(cur_tog, 1'b1, 1'b0);
        cmp("ack_clears", int'(bus.evt_pending), 0);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        idle(ACC_LAT + 2);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        for (int i = 1; i < ACC_LAT; i++) applyStimulus(cur_tog, 1'b0, 1'b0);
        applyStimulus(cur_tog, 1'b1, 1'b0);
        cmp("ack_accept_pulse", int'(bus.evt_pulse), 1);
        cmp("ack_accept_pending", int'(bus.evt_pending), 1);
        cmp("ack_accept_overrun", int'(bus.overrun), 0);
        applyStimulus(cur_tog, 1'b1, 1'b0);

        // Two unacked toggles: overrun sticks through a later ack, clears on reset.
        base = int'(bus.evt_count);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        idle(5);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        idle(5);
        cmp("overrun_count", int'(bus.evt_count), base + 2);
        cmp("overrun_set", int'(bus.overrun), 1);
        applyStimulus(cur_tog, 1'b1, 1'b0);
        cmp("overrun_ack_pending", int'(bus.evt_pending), 0);
        idle(4);
        cmp("overrun_sticky", int'(bus.overrun), 1);
        do_reset(cur_tog);
        cmp("overrun_reset", int'(bus.overrun), 0);
        idle(SYNC + 2);

        // 256 toggles spaced 8 cycles: count wraps back to 0.
        pulses = 0;
        for (int e = 0; e < 256; e++) begin
            applyStimulus(~cur_tog, 1'b0, 1'b0);
            if (bus.evt_pulse) pulses++;
            for (int i = 1; i < 8; i++) begin
                applyStimulus(cur_tog, 1'b0, 1'b0);
                if (bus.evt_pulse) pulses++;
            end
        end
        cmp("wrap_pulses", pulses, 256);
        cmp("wrap_count", int'(bus.evt_count), 0);

        // Two-cycle glitch: rejected by the filter, two events without it.
        base = int'(bus.evt_count);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        applyStimulus(cur_tog, 1'b0, 1'b0);
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        idle(8);
        cmp("glitch_events", int'(bus.evt_count) - base, GLITCH_EVS);

        // Reset while a toggle is in flight: everything clears and INIT swallows the new level.
        applyStimulus(~cur_tog, 1'b0, 1'b0);
        idle(2);
        applyStimulus(cur_tog, 1'b0, 1'b1);
        cmp("midreset_count", int'(bus.evt_count), 0);
        cmp("midreset_pending", int'(bus.evt_pending), 0);
        cmp("midreset_level", int'(bus.level_out), 0);
        idle(8);
        cmp("midreset_no_event", int'(bus.evt_count), 0);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            bit t, a, r;
            t = ($urandom_range(0, 3) == 0) ? ~cur_tog : cur_tog;
            a = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            applyStimulus(t, a, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive end of a toggle-signalling link: recovers discrete events from a line that a T flip-flop transmitter inverts once per event. Each level change on the asynchronous toggle line is synchronized into `clk` and produces a one-cycle event pulse, a wrapping event count, a pending flag with an acknowledge handshake, and a sticky overrun flag. It sits behind a dedicated input pin in the TT user design and feeds status logic and `uo_out`.

## Interface
Parameters:
- `CNT_W`, 8: event counter width.
- `SYNC_STAGES`, 2: synchronizer flop count, minimum 2.
- `FILT_LEN`, 3: filter hold length in cycles, minimum 1. Used only with `TOGGLE_FILTER_EN`.

Ports:
- `clk` input, 1: sole clock.
- `rst` input, 1: synchronous, active-high reset.
- `tog_in` input, 1: asynchronous toggle line.
- `ack_in` input, 1: consumer acknowledge for the pending event.
- `evt_pulse` output, 1: single-cycle strobe, one per accepted toggle.
- `evt_pending` output, 1: an unacknowledged event exists.
- `evt_count` output, `CNT_W`: accepted-event count, wraps.
- `overrun` output, 1: sticky flag; an event arrived while one was already pending and not being acked.
- `level_out` output, 1: accepted (synchronized, filtered) line level.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series on `tog_in`. All stages clear to 0 on reset. `sync_out` is the last stage.
- FSM states:
  - INIT: entered on reset. Stays for `SYNC_STAGES` cycles after `rst` deasserts. On exit, loads `level_q <= sync_out` with no event. This prevents a spurious event when the line is high at reset release.
  - RUN: normal detection. Stays in RUN until `rst` asserts.
- In INIT: `ack_in` is ignored and line changes are not counted.
- Detection in RUN, filter compiled out: `sync_out != level_q` is accepted on the next edge. On acceptance, `level_q` flips.
- Accept effects, all registered on the same edge:
  - `evt_pulse` = 1 for one cycle.
  - `evt_count` += 1, modulo 2^`CNT_W`.
  - `evt_pending` set.
  - `overrun` set if `evt_pending` was 1 and `ack_in` = 0 in that cycle.
- Handshake: `ack_in` = 1 while `evt_pending` = 1 clears `evt_pending` on the next edge. `ack_in` while not pending has no effect.
- Simultaneous accept and `ack_in`: `evt_pending` stays 1 (the new event) and no overrun is raised.
- `overrun` clears only on `rst`.
- Double toggle faster than detection: two quick toggles that return `sync_out` to `level_q` before acceptance produce no event. This is inherent to level encoding.
- Reset mid-operation: all state and outputs clear on that edge and the FSM re-enters INIT. Events in flight are lost.

## Timing
- Reset values: `evt_pulse` = 0, `evt_pending` = 0, `evt_count` = 0, `overrun` = 0, `level_out` = 0. After INIT, `level_out` = `sync_out`.
- INIT lasts `SYNC_STAGES` cycles after `rst` deasserts.
- Latency, no filter: edge k is the first edge sampling the new `tog_in`. `evt_pulse`, `evt_count`, `evt_pending` and `level_out` update at edge k+`SYNC_STAGES`, which is `SYNC_STAGES`+1 edges inclusive.
- Latency, with filter: the same outputs update at edge k+`SYNC_STAGES`+`FILT_LEN`-1.
- `FILT_LEN` = 1 with the filter compiled in matches the unfiltered timing.
- Maximum sustained rate: one accepted toggle per (`FILT_LEN`) cycles after the synchronizer.
- Ack-to-clear: one edge.

## Configuration
`TOGGLE_FILTER_EN`
- Defined: a hold counter of width ceil(log2(`FILT_LEN`+1)) runs in RUN.
  - It counts consecutive cycles with `sync_out != level_q`.
  - It resets to 0 whenever they are equal.
  - The toggle is accepted when the counter reaches `FILT_LEN`-1 with the mismatch still present.
  - Mismatches shorter than `FILT_LEN` cycles are discarded.
- Undefined: no counter; any mismatch is accepted on the next edge.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use defaults `SYNC_STAGES`=2, `FILT_LEN`=3.
- Reset release with line already high: hold `tog_in`=1, deassert `rst` -> after 2 INIT cycles `level_out`=1; `evt_pulse` never asserts; `evt_count`=0.
- Single toggle, no filter: `tog_in` 0->1 sampled at edge k -> `evt_pulse`=1 exactly in the cycle after edge k+2; `evt_count`=1; `evt_pending`=1.
- Handshake: `ack_in` pulsed while pending -> `evt_pending`=0 next edge. Toggle accepted on the same edge as `ack_in` -> `evt_pending` stays 1, `overrun`=0.
- Overrun and sticky: two toggles 6 cycles apart, no ack -> `evt_count`=2, `overrun`=1. Later ack -> `evt_pending`=0, `overrun` still 1 until `rst`.
- Counter wrap: 256 toggles spaced 8 cycles apart -> 256 pulses; `evt_count` wraps 255->0.
- Filter build, glitch vs hold: 2-cycle glitch -> no event. Hold for 3 cycles -> `evt_pulse` at edge k+4. Assert `rst` mid-hold -> all outputs 0 and no event.
